// File: rtl/bcd_mod_counter_pkg.sv
// clock_pkg: shared BCD types and helpers for the clock datapath counters.
// Optional down-count support is enabled with BCD_MOD_DOWN_EN.
package clock_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;
  typedef logic [BCD_W*MAX_DIGITS-1:0] bcd_vec_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_LOAD,
    ACT_SET_L,
    ACT_SET_H,
    ACT_TICK
  } act_e;

  function automatic bcd_vec_t bin2bcd(
    input int value,
    input int digits
  );
    bcd_vec_t r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[i*BCD_W +: BCD_W] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic int bcd2bin(
    input bcd_vec_t vec,
    input int digits
  );
    int r;
    int w;
    r = 0;
    w = 1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r = r + int'(vec[i*BCD_W +: BCD_W]) * w;
        w = w * 10;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_is_valid(
    input bcd_vec_t vec,
    input int digits,
    input int modulus
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && vec[i*BCD_W +: BCD_W] > 4'd9)
        ok = 1'b0;
    end
    if (bcd2bin(vec, digits) >= modulus)
      ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/status bundle of one BCD modulo counter stage.
// BCD_MOD_DOWN_EN adds the down select and borrow pulse.
interface bcd_mod_counter_if
  import clock_pkg::*;
#(
  parameter int DIGITS = 2
) ();

  logic                    tick;
  logic                    set_L;
  logic                    set_H;
  logic                    load;
  logic [BCD_W*DIGITS-1:0] load_val;
  logic [BCD_W*DIGITS-1:0] bcd;
  logic                    tc;
  logic                    carry;
  logic                    err;

`ifdef BCD_MOD_DOWN_EN
  logic down;
  logic borrow;

  modport master (
    output tick, set_L, set_H,
    output load, load_val, down,
    input  bcd, tc, carry,
    input  err, borrow
  );

  modport slave (
    input  tick, set_L, set_H,
    input  load, load_val, down,
    output bcd, tc, carry,
    output err, borrow
  );
`else
  modport master (
    output tick, set_L, set_H,
    output load, load_val,
    input  bcd, tc, carry, err
  );

  modport slave (
    input  tick, set_L, set_H,
    input  load, load_val,
    output bcd, tc, carry, err
  );
`endif

endinterface

// File: rtl/bcd_mod_counter_digit.sv
// bcd_digit: one BCD digit register with inc/dec, wrap target, clear and force.
// Optional down-count support of the parent is enabled with BCD_MOD_DOWN_EN.
module bcd_digit
  import clock_pkg::*;
#(
  parameter bcd_digit_t INIT = '0
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  input  logic       frc,
  input  bcd_digit_t mx,
  input  bcd_digit_t fv,
  output bcd_digit_t q,
  output logic       co,
  output logic       bo
);

  // mx is the wrap target: inc wraps after it, dec from 0 lands on it
  always_ff @(posedge clk_1) begin
    if (rst)
      q <= INIT;
    else if (frc)
      q <= fv;
    else if (clr)
      q <= '0;
    else if (inc)
      q <= (q == mx) ? '0 : q + 4'd1;
    else if (dec)
      q <= (q == '0) ? mx : q - 4'd1;
  end

  assign co = (q == 4'd9);
  assign bo = (q == '0);

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter with carry chain, manual set and checked load.
// Define BCD_MOD_DOWN_EN to add down-counting with a borrow pulse.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 24,
  parameter int INIT    = 23
) (
  input logic              clk_1,
  input logic              rst,
  bcd_mod_counter_if.slave bus
);

  localparam int W      = BCD_W * DIGITS;
  localparam int P      = 10 ** (DIGITS - 1);
  localparam int MAXV   = MODULUS - 1;
  localparam int TOPMAX = MAXV / P;

  localparam bcd_vec_t MAX16  = bin2bcd(MAXV, DIGITS);
  localparam bcd_vec_t INIT16 = bin2bcd(INIT, DIGITS);
  localparam logic [W-1:0] MAX_BCD = MAX16[W-1:0];

  if (DIGITS < 1 || DIGITS > MAX_DIGITS ||
      MODULUS < 2 || MODULUS > 10 ** DIGITS ||
      INIT < 0 || INIT >= MODULUS) begin : g_bad_param
    $error("bcd_mod_counter: illegal DIGITS/MODULUS/INIT");
  end

  logic [W-1:0]      q;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] dec;
  logic [DIGITS-1:0] clr;
  logic [DIGITS-1:0] frc;
  logic [DIGITS-1:0] co;
  logic [DIGITS-1:0] bo;
  logic [W-1:0]      mx;
  logic [W-1:0]      fv;

  bcd_vec_t   cur;
  bcd_vec_t   ldv;
  logic       ld_ok;
  act_e       act;
  bcd_digit_t d0;
  bcd_digit_t top;
  int         val;
  int         rest;
  int         low_v;
  int         nd;
  int         nt;
  logic       dn;
  logic       carry_d;
  logic       carry_q;
  logic       err_d;
  logic       err_q;

`ifdef BCD_MOD_DOWN_EN
  logic borrow_d;
  logic borrow_q;
  assign dn = bus.down;
`else
  assign dn = 1'b0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit #(
      .INIT (INIT16[i*BCD_W +: BCD_W])
    ) u_dig (
      .clk_1 (clk_1),
      .rst   (rst),
      .inc   (inc[i]),
      .dec   (dec[i]),
      .clr   (clr[i]),
      .frc   (frc[i]),
      .mx    (mx[i*BCD_W +: BCD_W]),
      .fv    (fv[i*BCD_W +: BCD_W]),
      .q     (q[i*BCD_W +: BCD_W]),
      .co    (co[i]),
      .bo    (bo[i])
    );
  end

  assign cur   = bcd_vec_t'(q);
  assign ldv   = bcd_vec_t'(bus.load_val);
  assign ld_ok = bcd_is_valid(ldv, DIGITS, MODULUS);

  always_comb begin
    act = ACT_NONE;
    if (bus.load)
      act = ACT_LOAD;
    else if (bus.set_L)
      act = ACT_SET_L;
    else if (bus.set_H)
      act = ACT_SET_H;
    else if (bus.tick)
      act = ACT_TICK;
  end

  always_comb begin
    logic lo9;
    logic lo0;
    val     = bcd2bin(cur, DIGITS);
    d0      = q[BCD_W-1:0];
    top     = q[W-1 -: BCD_W];
    rest    = val - int'(d0);
    low_v   = val - int'(top) * P;
    nd      = 0;
    nt      = 0;
    inc     = '0;
    dec     = '0;
    clr     = '0;
    frc     = '0;
    mx      = {DIGITS{4'd9}};
    fv      = '0;
    carry_d = 1'b0;
    err_d   = 1'b0;
`ifdef BCD_MOD_DOWN_EN
    borrow_d = 1'b0;
`endif
    lo9 = 1'b1;
    lo0 = 1'b1;
    unique case (act)
      ACT_NONE: ;
      ACT_LOAD: begin
        if (ld_ok) begin
          frc = '1;
          fv  = bus.load_val;
        end else begin
          err_d = 1'b1;
        end
      end
      ACT_SET_L: begin
        // going down from 0 lands on the largest value the upper digits allow
        if (dn)
          nd = (d0 == 4'd0)
             ? ((MAXV - rest > 9) ? 9 : MAXV - rest)
             : int'(d0) - 1;
        else
          nd = (d0 == 4'd9 || val + 1 >= MODULUS)
             ? 0 : int'(d0) + 1;
        frc[0]          = 1'b1;
        fv[BCD_W-1:0]   = 4'(nd);
      end
      ACT_SET_H: begin
        if (dn)
          nt = (top == 4'd0) ? TOPMAX : int'(top) - 1;
        else
          nt = (top == 4'd9 || int'(top) == TOPMAX)
             ? 0 : int'(top) + 1;
        if (nt * P + low_v >= MODULUS) begin
          frc = '1;
          fv  = MAX_BCD;
        end else begin
          frc[DIGITS-1]     = 1'b1;
          fv[W-1 -: BCD_W]  = 4'(nt);
        end
      end
      ACT_TICK: begin
        if (dn) begin
          if (q == '0) begin
            dec = '1;
            mx  = MAX_BCD;
`ifdef BCD_MOD_DOWN_EN
            borrow_d = 1'b1;
`endif
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              dec[i] = lo0;
              lo0    = lo0 & bo[i];
            end
          end
        end else if (q == MAX_BCD) begin
          clr     = '1;
          carry_d = 1'b1;
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            inc[i] = lo9;
            lo9    = lo9 & co[i];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

`ifdef BCD_MOD_DOWN_EN
  always_ff @(posedge clk_1) begin
    if (rst)
      borrow_q <= 1'b0;
    else
      borrow_q <= borrow_d;
  end

  assign bus.borrow = borrow_q;
`endif

  assign bus.bcd   = q;
  assign bus.tc    = dn ? (q == '0) : (q == MAX_BCD);
  assign bus.carry = carry_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: 24-hour counter against an arithmetic model,
// plus an HH:MM:SS chain; down-count cases only with BCD_MOD_DOWN_EN.
module tb_bcd_mod_counter;
  import clock_pkg::*;

  localparam int M      = 24;
  localparam int INIT_V = 23;

  logic clk_1 = 1'b0;
  logic rst   = 1'b1;
  logic tb_dn = 1'b0;
  logic chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   hc     = 0;

  always #5 clk_1 = ~clk_1;

  bcd_mod_counter_if #(.DIGITS(2)) m_if ();
  bcd_mod_counter_if #(.DIGITS(2)) s_if ();
  bcd_mod_counter_if #(.DIGITS(2)) n_if ();
  bcd_mod_counter_if #(.DIGITS(2)) h_if ();

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .INIT(23)) dut (
    .clk_1 (clk_1),
    .rst   (rst),
    .bus   (m_if)
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .INIT(59)) u_sec (
    .clk_1 (clk_1),
    .rst   (rst),
    .bus   (s_if)
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .INIT(59)) u_min (
    .clk_1 (clk_1),
    .rst   (rst),
    .bus   (n_if)
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .INIT(23)) u_hr (
    .clk_1 (clk_1),
    .rst   (rst),
    .bus   (h_if)
  );

  assign n_if.tick = s_if.tick & s_if.tc;
  assign h_if.tick = n_if.tick & n_if.tc;

`ifdef BCD_MOD_DOWN_EN
  assign m_if.down = tb_dn;
  assign s_if.down = 1'b0;
  assign n_if.down = 1'b0;
  assign h_if.down = 1'b0;
`endif

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // reference model: the count held as a plain integer
  int mv;
  bit mc, me, mb;

  always @(posedge clk_1) begin
    int d0, rest, t, lo, hi_d, lo_d;
    mc = 1'b0;
    me = 1'b0;
    mb = 1'b0;
    if (rst) begin
      mv = INIT_V;
    end else if (m_if.load) begin
      hi_d = int'(m_if.load_val[7:4]);
      lo_d = int'(m_if.load_val[3:0]);
      if (hi_d <= 9 && lo_d <= 9 && hi_d * 10 + lo_d < M)
        mv = hi_d * 10 + lo_d;
      else
        me = 1'b1;
    end else if (m_if.set_L) begin
      d0   = mv % 10;
      rest = mv - d0;
      if (tb_dn)
        d0 = (d0 == 0) ? ((M - 1 - rest > 9) ? 9 : M - 1 - rest) : d0 - 1;
      else
        d0 = (d0 == 9 || mv + 1 >= M) ? 0 : d0 + 1;
      mv = rest + d0;
    end else if (m_if.set_H) begin
      t  = mv / 10;
      lo = mv % 10;
      if (tb_dn)
        t = (t == 0) ? (M - 1) / 10 : t - 1;
      else
        t = (t == 9 || t == (M - 1) / 10) ? 0 : t + 1;
      mv = t * 10 + lo;
      if (mv >= M) mv = M - 1;
    end else if (m_if.tick) begin
      if (tb_dn) begin
        if (mv == 0) begin
          mv = M - 1;
          mb = 1'b1;
        end else begin
          mv = mv - 1;
        end
      end else if (mv == M - 1) begin
        mv = 0;
        mc = 1'b1;
      end else begin
        mv = mv + 1;
      end
    end
  end

  always @(negedge clk_1) begin
    if (chk_en) begin
      cmp("model_bcd", 16'(m_if.bcd), 16'(to_bcd(mv)));
      cmp("model_tc", 16'(m_if.tc),
          16'(tb_dn ? (mv == 0) : (mv == M - 1)));
      cmp("model_carry", 16'(m_if.carry), 16'(mc));
      cmp("model_err", 16'(m_if.err), 16'(me));
`ifdef BCD_MOD_DOWN_EN
      cmp("model_borrow", 16'(m_if.borrow), 16'(mb));
`endif
    end
    if (h_if.carry === 1'b1) hc++;
  end

  task automatic drive(input bit tk, input bit sl, input bit sh,
                       input bit ld, input logic [7:0] lv);
    m_if.tick     = tk;
    m_if.set_L    = sl;
    m_if.set_H    = sh;
    m_if.load     = ld;
    m_if.load_val = lv;
    @(negedge clk_1);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 8'h00);
  endtask

  task automatic ld(input logic [7:0] v);
    drive(0, 0, 0, 1, v);
  endtask

  initial begin
    m_if.tick = 0; m_if.set_L = 0; m_if.set_H = 0;
    m_if.load = 0; m_if.load_val = '0;
    s_if.tick = 0; s_if.set_L = 0; s_if.set_H = 0;
    s_if.load = 0; s_if.load_val = '0;
    n_if.set_L = 0; n_if.set_H = 0;
    n_if.load = 0; n_if.load_val = '0;
    h_if.set_L = 0; h_if.set_H = 0;
    h_if.load = 0; h_if.load_val = '0;

    rst = 1'b1;
    @(negedge clk_1);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    cmp("reset_bcd", 16'(m_if.bcd), 16'h23);
    cmp("reset_tc", 16'(m_if.tc), 16'h1);
    cmp("reset_carry", 16'(m_if.carry), 16'h0);
    cmp("reset_err", 16'(m_if.err), 16'h0);

    drive(1, 0, 0, 0, 8'h00);
    cmp("wrap_bcd", 16'(m_if.bcd), 16'h00);
    cmp("wrap_carry", 16'(m_if.carry), 16'h1);
    idle();
    cmp("wrap_carry_drop", 16'(m_if.carry), 16'h0);

    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 8'h00);
      cmp("ten_carry", 16'(m_if.carry), 16'h0);
    end
    cmp("ten_bcd", 16'(m_if.bcd), 16'h10);

    ld(8'h19);
    cmp("load19", 16'(m_if.bcd), 16'h19);
    drive(0, 0, 1, 0, 8'h00);
    cmp("setH_clamp", 16'(m_if.bcd), 16'h23);
    drive(0, 1, 0, 0, 8'h00);
    cmp("setL_wrap", 16'(m_if.bcd), 16'h20);
    drive(1, 1, 0, 0, 8'h00);
    cmp("setL_over_tick", 16'(m_if.bcd), 16'h21);
    cmp("setL_no_carry", 16'(m_if.carry), 16'h0);

    ld(8'h17);
    cmp("load17", 16'(m_if.bcd), 16'h17);
    ld(8'h24);
    cmp("load24_bcd", 16'(m_if.bcd), 16'h17);
    cmp("load24_err", 16'(m_if.err), 16'h1);
    idle();
    cmp("err_drop", 16'(m_if.err), 16'h0);
    ld(8'h1A);
    cmp("load1A_err", 16'(m_if.err), 16'h1);
    cmp("load1A_bcd", 16'(m_if.bcd), 16'h17);
    drive(1, 0, 0, 1, 8'h05);
    cmp("load_over_tick", 16'(m_if.bcd), 16'h05);

    ld(8'h00);
    drive(0, 0, 1, 0, 8'h00);
    cmp("setH_0_10", 16'(m_if.bcd), 16'h10);
    drive(0, 0, 1, 0, 8'h00);
    cmp("setH_10_20", 16'(m_if.bcd), 16'h20);
    drive(0, 0, 1, 0, 8'h00);
    cmp("setH_20_00", 16'(m_if.bcd), 16'h00);
    ld(8'h09);
    drive(0, 1, 0, 0, 8'h00);
    cmp("setL_9_0", 16'(m_if.bcd), 16'h00);
    drive(0, 1, 1, 0, 8'h00);
    cmp("setL_over_setH", 16'(m_if.bcd), 16'h01);

    ld(8'h20);
    for (int i = 0; i < 30; i++) drive(1, 0, 0, 0, 8'h00);
    cmp("sweep_bcd", 16'(m_if.bcd), 16'h02);

    ld(8'h23);
    rst = 1'b1;
    drive(1, 0, 0, 0, 8'h00);
    rst = 1'b0;
    cmp("rst_tick_bcd", 16'(m_if.bcd), 16'h23);
    cmp("rst_tick_carry", 16'(m_if.carry), 16'h0);
    idle();
    cmp("rst_tick_after", 16'(m_if.carry), 16'h0);

    cmp("chain_s0", 16'(s_if.bcd), 16'h59);
    cmp("chain_m0", 16'(n_if.bcd), 16'h59);
    cmp("chain_h0", 16'(h_if.bcd), 16'h23);
    cmp("chain_htc", 16'(h_if.tc), 16'h1);
    cmp("chain_pre_hc", 16'(hc), 16'h0);
    s_if.tick = 1'b1;
    @(negedge clk_1);
    #1;
    s_if.tick = 1'b0;
    cmp("chain_s1", 16'(s_if.bcd), 16'h00);
    cmp("chain_m1", 16'(n_if.bcd), 16'h00);
    cmp("chain_h1", 16'(h_if.bcd), 16'h00);
    cmp("chain_hcarry", 16'(h_if.carry), 16'h1);
    repeat (3) @(negedge clk_1);
    #1;
    cmp("chain_hc_once", 16'(hc), 16'h1);
    s_if.tick = 1'b1;
    @(negedge clk_1);
    #1;
    s_if.tick = 1'b0;
    cmp("chain_s2", 16'(s_if.bcd), 16'h01);
    cmp("chain_m2", 16'(n_if.bcd), 16'h00);

`ifdef BCD_MOD_DOWN_EN
    tb_dn = 1'b1;
    ld(8'h00);
    drive(1, 0, 0, 0, 8'h00);
    cmp("down_wrap", 16'(m_if.bcd), 16'h23);
    cmp("down_borrow", 16'(m_if.borrow), 16'h1);
    cmp("down_carry", 16'(m_if.carry), 16'h0);
    idle();
    cmp("down_borrow_drop", 16'(m_if.borrow), 16'h0);
    drive(1, 0, 0, 0, 8'h00);
    cmp("down_22", 16'(m_if.bcd), 16'h22);
    ld(8'h20);
    drive(0, 1, 0, 0, 8'h00);
    cmp("down_setL", 16'(m_if.bcd), 16'h23);
    drive(0, 0, 1, 0, 8'h00);
    cmp("down_setH", 16'(m_if.bcd), 16'h13);
    ld(8'h03);
    drive(0, 0, 1, 0, 8'h00);
    cmp("down_setH_wrap", 16'(m_if.bcd), 16'h23);
    ld(8'h10);
    for (int i = 0; i < 12; i++) drive(1, 0, 0, 0, 8'h00);
    cmp("down_sweep", 16'(m_if.bcd), 16'h22);
    ld(8'h00);
    rst = 1'b1;
    drive(1, 0, 0, 0, 8'h00);
    rst = 1'b0;
    cmp("down_rst_bcd", 16'(m_if.bcd), 16'h23);
    cmp("down_rst_borrow", 16'(m_if.borrow), 16'h0);
    idle();
    cmp("down_rst_after", 16'(m_if.borrow), 16'h0);
    tb_dn = 1'b0;
    idle();
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
